// File: rtl/wmem_stream.sv
// wmem_stream: filter weight memory with a valid/ready load port.
// On start it streams one stored filter to the PPE rows as router packets,
// then sends a weights-done packet to IMEM.
module wmem_stream #(
  parameter int WEIGHT_W        = 8,
  parameter int FILTER_SIZE     = 5,
  parameter int NUM_FILTERS     = 2,
  parameter int PACK            = 3,
  parameter int ADDR_W          = 4,
  parameter int OP_W            = 4,
  parameter int DATA_W          = 25,
  parameter int PPE_BASE        = 5,
  parameter int IMEM_ID         = 11,
  parameter int OP_WEIGHT       = 0,
  parameter int OP_WEIGHTS_DONE = 2,
  localparam int FS2   = FILTER_SIZE * FILTER_SIZE,
  localparam int DEPTH = NUM_FILTERS * FS2,
  localparam int AW    = $clog2(DEPTH),
  localparam int FW    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int PKT_W = ADDR_W + OP_W + DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [AW-1:0]     ld_addr,
  input  logic [WEIGHT_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              start,
  input  logic [FW-1:0]     sel_filter,
  output logic              busy,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic [PKT_W-1:0]  pkt_data,
  output logic              done,
  output logic              err
);

  localparam int PPR = (FILTER_SIZE + PACK - 1) / PACK;
  localparam int RW  = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE + 1) : 1;
  localparam int PW  = (PPR > 1) ? $clog2(PPR) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, FIN = 2'd2} state_t;

  state_t                state;
  logic [WEIGHT_W-1:0]   mem [DEPTH];
  logic [NUM_FILTERS-1:0] loaded;
  logic [FW-1:0]         filt;
  logic [RW-1:0]         row;
  logic [PW-1:0]         pidx;

  logic                  wr_ok;
  logic                  wr_bad;
  logic [FW-1:0]         ld_fidx;
  logic                  sel_ok;
  logic [RW-1:0]         nxt_row;
  logic [PW-1:0]         nxt_pidx;
  logic [DATA_W-1:0]     nxt_weights;
  logic [PKT_W-1:0]      nxt_pkt;
  logic [PKT_W-1:0]      fin_pkt;

  // Decode load-port handshake and start eligibility.
  always_comb begin
    wr_ok   = 1'b0;
    wr_bad  = 1'b0;
    ld_fidx = '0;
    sel_ok  = 1'b0;
    if (state == IDLE && ld_valid && ld_ready) begin
      if (int'(ld_addr) < DEPTH) begin
        wr_ok   = 1'b1;
        ld_fidx = FW'(int'(ld_addr) / FS2);
      end else begin
        wr_bad = 1'b1;
      end
    end else begin
      wr_ok  = 1'b0;
      wr_bad = 1'b0;
    end
    if (int'(sel_filter) < NUM_FILTERS) begin
      sel_ok = loaded[sel_filter];
    end else begin
      sel_ok = 1'b0;
    end
  end

  // Build the packet that follows the one currently presented (or the first one).
  always_comb begin
    int col;
    int addr;
    col         = 0;
    addr        = 0;
    nxt_row     = '0;
    nxt_pidx    = '0;
    nxt_weights = '0;
    if (!pkt_valid) begin
      nxt_row  = '0;
      nxt_pidx = '0;
    end else if (int'(pidx) == PPR - 1) begin
      nxt_row  = row + 1'b1;
      nxt_pidx = '0;
    end else begin
      nxt_row  = row;
      nxt_pidx = pidx + 1'b1;
    end
    for (int k = 0; k < PACK; k++) begin
      col  = int'(nxt_pidx) * PACK + k;
      addr = int'(filt) * FS2 + int'(nxt_row) * FILTER_SIZE + col;
      if (col < FILTER_SIZE && addr < DEPTH) begin
        nxt_weights[k*WEIGHT_W +: WEIGHT_W] = mem[AW'(addr)];
      end else begin
        nxt_weights[k*WEIGHT_W +: WEIGHT_W] = '0;
      end
    end
    nxt_pkt = {ADDR_W'(PPE_BASE + int'(nxt_row)), OP_W'(OP_WEIGHT), nxt_weights};
    fin_pkt = {ADDR_W'(IMEM_ID), OP_W'(OP_WEIGHTS_DONE), DATA_W'(filt)};
  end

  // Weight storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      loaded    <= '0;
      filt      <= '0;
      row       <= '0;
      pidx      <= '0;
      ld_ready  <= 1'b1;
      busy      <= 1'b0;
      pkt_valid <= 1'b0;
      pkt_data  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          ld_ready <= 1'b1;
          if (wr_ok && ld_last) begin
            loaded[ld_fidx] <= 1'b1;
          end
          if (start && sel_ok) begin
            filt     <= sel_filter;
            row      <= '0;
            pidx     <= '0;
            busy     <= 1'b1;
            ld_ready <= 1'b0;
            state    <= SEND;
          end
          if (wr_bad || (start && !sel_ok)) begin
            err <= 1'b1;
          end
        end
        SEND: begin
          if (!pkt_valid) begin
            pkt_valid <= 1'b1;
            pkt_data  <= nxt_pkt;
            row       <= nxt_row;
            pidx      <= nxt_pidx;
          end else if (pkt_ready) begin
            if (int'(pidx) == PPR - 1 && int'(row) == FILTER_SIZE - 1) begin
              pkt_data <= fin_pkt;
              state    <= FIN;
            end else begin
              pkt_data <= nxt_pkt;
              row      <= nxt_row;
              pidx     <= nxt_pidx;
            end
          end
        end
        FIN: begin
          if (pkt_ready) begin
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
            done      <= 1'b1;
            busy      <= 1'b0;
            ld_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          pkt_valid <= 1'b0;
          busy      <= 1'b0;
          ld_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
